pred_lt_3: RTL and testbench

- Decoder-side long-term (adaptive-codebook) predictor; G.729 Pred_lt_3 with 1/3 resolution.
- Reads past excitation from scratch memory at integer lag T0 and fraction frac.
- Interpolates with the 10-tap-per-side inter_3l filter from constant memory.
- Writes L_subfr excitation samples back to scratch memory in place.
- Uses the shared L_mac and L_add units through the same mux-port style as the other pitch blocks.

---
 rtl/pred_lt_3.sv | 167 ++++++++++++++++
 tb/tb_pred_lt_3.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pred_lt_3.sv
// Long-term (adaptive-codebook) predictor with 1/3 resolution. It interpolates past
// excitation with the inter_3l filter and writes the new excitation back in place.
module pred_lt_3 #(
  parameter int L_INTER10 = 10,
  parameter int UP_SAMP   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] exc,
  input  logic [15:0] T0,
  input  logic [15:0] frac,
  input  logic [15:0] L_subfr,
  input  logic [11:0] inter_3l,
  input  logic [31:0] L_macIn,
  input  logic [31:0] L_addIn,
  input  logic [31:0] FSMdataInScratch,
  input  logic [31:0] FSMdataInConstant,
  output logic [15:0] L_macOutA,
  output logic [15:0] L_macOutB,
  output logic [31:0] L_macOutC,
  output logic [31:0] L_addOutA,
  output logic [31:0] L_addOutB,
  output logic [11:0] FSMreadAddrScratch,
  output logic [11:0] FSMreadAddrConstant,
  output logic [11:0] FSMwriteAddrScratch,
  output logic [31:0] FSMwriteDataScratch,
  output logic        FSMwriteEnScratch,
  output logic        done
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_RD1, S_MAC1, S_RD2, S_MAC2, S_RND, S_WR, S_DONE
  } state_t;

  localparam logic [3:0]  LAST_TAP = 4'(L_INTER10 - 1);
  localparam logic [11:0] STRIDE   = 12'(UP_SAMP);

  state_t      r_state, w_next;
  logic [1:0]  r_f;
  logic [11:0] r_base, r_exc, r_tab;
  logic [15:0] r_len, r_j;
  logic [3:0]  r_i;
  logic [31:0] r_s;
  logic [15:0] r_r;

  logic [15:0] w_nfrac;
  logic        w_fneg;
  logic [1:0]  w_f_init;
  logic [11:0] w_base_init, w_i3, w_j12, w_f12;
  logic        w_unused_bits;

  // The fraction is negated; a negative result borrows one whole sample from the base.
  assign w_nfrac     = 16'd0 - frac;
  assign w_fneg      = w_nfrac[15];
  assign w_f_init    = w_fneg ? 2'(w_nfrac + 16'd3) : w_nfrac[1:0];
  assign w_base_init = exc - T0[11:0] - {11'd0, w_fneg};

  assign w_i3  = {8'd0, r_i} * STRIDE;
  assign w_j12 = r_j[11:0];
  assign w_f12 = {10'd0, r_f};

  assign w_unused_bits = ^{T0[15:12], w_nfrac[14:2], L_addIn[15:0],
                           FSMdataInScratch[31:16], FSMdataInConstant[31:16]};

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output gets a default before the case, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    w_next              = r_state;
    L_macOutA           = '0;
    L_macOutB           = '0;
    L_macOutC           = '0;
    L_addOutA           = '0;
    L_addOutB           = '0;
    FSMreadAddrScratch  = '0;
    FSMreadAddrConstant = '0;
    FSMwriteAddrScratch = '0;
    FSMwriteDataScratch = '0;
    FSMwriteEnScratch   = 1'b0;
    done                = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_INIT;
      S_INIT: w_next = (L_subfr == 16'd0) ? S_DONE : S_RD1;
      S_RD1: begin
        FSMreadAddrScratch  = r_base + w_j12 - {8'd0, r_i};
        FSMreadAddrConstant = r_tab + w_f12 + w_i3;
        w_next              = S_MAC1;
      end
      S_MAC1, S_MAC2: begin
        L_macOutA = FSMdataInScratch[15:0];
        L_macOutB = FSMdataInConstant[15:0];
        L_macOutC = r_s;
        if (r_state == S_MAC1)    w_next = S_RD2;
        else if (r_i == LAST_TAP) w_next = S_RND;
        else                      w_next = S_RD1;
      end
      S_RD2: begin
        FSMreadAddrScratch  = r_base + w_j12 + 12'd1 + {8'd0, r_i};
        FSMreadAddrConstant = r_tab + (STRIDE - w_f12) + w_i3;
        w_next              = S_MAC2;
      end
      S_RND: begin
        L_addOutA = r_s;
        L_addOutB = 32'h0000_8000;
        w_next    = S_WR;
      end
      S_WR: begin
        FSMwriteEnScratch   = 1'b1;
        FSMwriteAddrScratch = r_exc + w_j12;
        FSMwriteDataScratch = {{16{r_r[15]}}, r_r};
        w_next              = (r_j + 16'd1 == r_len) ? S_DONE : S_RD1;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_f    <= '0;
      r_base <= '0;
      r_exc  <= '0;
      r_tab  <= '0;
      r_len  <= '0;
      r_j    <= '0;
      r_i    <= '0;
      r_s    <= '0;
      r_r    <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_f    <= w_f_init;
          r_base <= w_base_init;
          r_exc  <= exc;
          r_tab  <= inter_3l;
          r_len  <= L_subfr;
          r_j    <= '0;
          r_i    <= '0;
          r_s    <= '0;
        end
        S_MAC1: r_s <= L_macIn;
        S_MAC2: begin
          r_s <= L_macIn;
          r_i <= (r_i == LAST_TAP) ? 4'd0 : r_i + 4'd1;
        end
        S_RND: r_r <= L_addIn[31:16];
        S_WR: begin
          r_s <= '0;
          r_i <= '0;
          r_j <= r_j + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pred_lt_3.sv
// Scoreboard bench for pred_lt_3: a G.729-level reference model predicts every
// excitation write, and a monitor checks the DUT's writes against that queue.
module tb_pred_lt_3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] exc;
  logic [15:0] T0, frac, L_subfr;
  logic [11:0] inter_3l;
  logic [31:0] L_macIn, L_addIn, FSMdataInScratch, FSMdataInConstant;
  logic [15:0] L_macOutA, L_macOutB;
  logic [31:0] L_macOutC, L_addOutA, L_addOutB;
  logic [11:0] FSMreadAddrScratch, FSMreadAddrConstant, FSMwriteAddrScratch;
  logic [31:0] FSMwriteDataScratch;
  logic        FSMwriteEnScratch, done;

  always #5 clk = ~clk;

  pred_lt_3 dut (
    .clk(clk), .reset(reset), .start(start), .exc(exc), .T0(T0), .frac(frac),
    .L_subfr(L_subfr), .inter_3l(inter_3l), .L_macIn(L_macIn), .L_addIn(L_addIn),
    .FSMdataInScratch(FSMdataInScratch), .FSMdataInConstant(FSMdataInConstant),
    .L_macOutA(L_macOutA), .L_macOutB(L_macOutB), .L_macOutC(L_macOutC),
    .L_addOutA(L_addOutA), .L_addOutB(L_addOutB),
    .FSMreadAddrScratch(FSMreadAddrScratch), .FSMreadAddrConstant(FSMreadAddrConstant),
    .FSMwriteAddrScratch(FSMwriteAddrScratch), .FSMwriteDataScratch(FSMwriteDataScratch),
    .FSMwriteEnScratch(FSMwriteEnScratch), .done(done)
  );

  // ITU basic operators with 32-bit saturation.
  localparam longint MAX32 = 64'sd2147483647;
  localparam longint MIN32 = -64'sd2147483648;

  function automatic logic [31:0] sat32(input longint v);
    if (v > MAX32) return 32'h7FFF_FFFF;
    if (v < MIN32) return 32'h8000_0000;
    return v[31:0];
  endfunction

  function automatic logic [31:0] l_add(input logic [31:0] a, input logic [31:0] b);
    return sat32(longint'($signed(a)) + longint'($signed(b)));
  endfunction

  function automatic logic [31:0] l_mac(input logic [31:0] acc, input logic [15:0] a,
                                        input logic [15:0] b);
    longint p;
    logic [31:0] prod;
    p = longint'($signed(a)) * longint'($signed(b));
    if (p == 64'sd1073741824) prod = 32'h7FFF_FFFF;
    else                      prod = 32'(p * 2);
    return l_add(acc, prod);
  endfunction

  assign L_macIn = l_mac(L_macOutC, L_macOutA, L_macOutB);
  assign L_addIn = l_add(L_addOutA, L_addOutB);

  // Memories with one-cycle read; upper data bits carry junk the DUT must ignore.
  logic [15:0] scr      [4096];
  logic [15:0] scr_init [4096];
  logic [15:0] cst      [4096];
  logic        load;

  always @(posedge clk) begin
    if (load) scr <= scr_init;
    else if (FSMwriteEnScratch) scr[FSMwriteAddrScratch] <= FSMwriteDataScratch[15:0];
    FSMdataInScratch  <= {~scr[FSMreadAddrScratch], scr[FSMreadAddrScratch]};
    FSMdataInConstant <= {~cst[FSMreadAddrConstant], cst[FSMreadAddrConstant]};
  end

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  n_writes = 0;
  int  tab = 300;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (FSMwriteEnScratch === 1'b1) begin
      wr_t e;
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {20'd0, FSMwriteAddrScratch}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {20'd0, FSMwriteAddrScratch}, {20'd0, e.addr});
        check("wr_data", FSMwriteDataScratch, e.data);
      end
    end
  end

  // Reference: Pred_lt_3 on a private copy of the excitation, one sample at a time.
  task automatic model(input int exc_a, input int t0, input int fr, input int lsub);
    logic [15:0] m [4096];
    logic [31:0] s, rnd;
    int f, x0;
    wr_t e;
    m  = scr_init;
    f  = -fr;
    x0 = exc_a - t0;
    if (f < 0) begin
      f  = f + 3;
      x0 = x0 - 1;
    end
    for (int j = 0; j < lsub; j++) begin
      s = 32'd0;
      for (int i = 0; i < 10; i++) begin
        s = l_mac(s, m[12'(x0 + j - i)], cst[12'(tab + f + 3 * i)]);
        s = l_mac(s, m[12'(x0 + j + 1 + i)], cst[12'(tab + 3 - f + 3 * i)]);
      end
      rnd = l_add(s, 32'h0000_8000);
      m[12'(exc_a + j)] = rnd[31:16];
      e.addr = 12'(exc_a + j);
      e.data = {{16{rnd[31]}}, rnd[31:16]};
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 4096; a++) begin
      scr_init[a] = 16'd0;
      cst[a]      = 16'd0;
    end
  endtask

  task automatic run(input string name, input int exc_a, input int t0, input int fr,
                     input int lsub, input int abort_at, input int busy_at);
    int w0, done_at;
    bit aborted;
    model(exc_a, t0, fr, lsub);
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
    exc      = 12'(exc_a);
    T0       = 16'(t0);
    frac     = 16'(fr);
    L_subfr  = 16'(lsub);
    inter_3l = 12'(tab);
    start    = 1'b1;
    w0       = n_writes;
    done_at  = -1;
    aborted  = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 2 + 42 * lsub + 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 2) begin
        exc      = 12'($urandom);
        T0       = 16'($urandom);
        frac     = 16'($urandom);
        L_subfr  = 16'($urandom);
        inter_3l = 12'($urandom);
      end
      if (k == busy_at)     start = 1'b1;
      if (k == busy_at + 1) start = 1'b0;
      if (k == abort_at) begin
        reset = 1'b0;
        #1;
        check({name, "_abort_wen"}, {31'd0, FSMwriteEnScratch}, 32'd0);
        check({name, "_abort_outs_zero"},
              {31'd0, |{L_macOutA, L_macOutB, L_macOutC, L_addOutA, L_addOutB,
                        FSMreadAddrScratch, FSMreadAddrConstant, FSMwriteAddrScratch,
                        FSMwriteDataScratch, FSMwriteEnScratch, done}}, 32'd0);
        aborted = 1'b1;
        break;
      end
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
    end
    if (aborted) begin
      repeat (6) @(negedge clk);
      check({name, "_abort_writes"}, 32'(n_writes - w0), 32'((abort_at - 2) / 42));
      exp_q.delete();
      reset = 1'b1;
      @(negedge clk);
    end else begin
      check({name, "_done_cycle"}, 32'(done_at), 32'(2 + 42 * lsub));
      @(negedge clk);
      check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({name, "_write_count"}, 32'(n_writes - w0), 32'(lsub));
      check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    end
  endtask

  task automatic setup_halving();
    clear_mem();
    cst[tab] = 16'h4000;
    for (int n = -40; n <= -1; n++) scr_init[12'(100 + n)] = 16'd1000;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; load = 1'b0;
    exc = '0; T0 = '0; frac = '0; L_subfr = '0; inter_3l = '0;
    clear_mem();
    repeat (3) @(negedge clk);
    check("reset_outs_zero",
          {31'd0, |{L_macOutA, L_macOutB, L_macOutC, L_addOutA, L_addOutB,
                    FSMreadAddrScratch, FSMreadAddrConstant, FSMwriteAddrScratch,
                    FSMwriteDataScratch, FSMwriteEnScratch, done}}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    setup_halving();
    run("halving", 100, 40, 0, 40, 0, 0);
    check("halving_exc0", {16'd0, scr[100]}, 32'd500);
    check("halving_exc39", {16'd0, scr[139]}, 32'd500);

    clear_mem();
    cst[tab + 2] = 16'h4000;
    for (int n = -41; n <= -1; n++) scr_init[12'(100 + n)] = 16'(4 * (n + 50));
    run("frac_p1", 100, 40, 1, 2, 0, 0);
    check("frac_p1_exc0", {16'd0, scr[100]}, 32'd18);
    check("frac_p1_exc1", {16'd0, scr[101]}, 32'd20);
    run("frac_m1", 100, 40, -1, 1, 0, 0);
    check("frac_m1_exc0", {16'd0, scr[100]}, 32'd22);

    clear_mem();
    cst[tab] = 16'h4000;
    for (int n = -20; n <= -1; n++) scr_init[12'(100 + n)] = 16'd1024;
    run("recursion", 100, 20, 0, 40, 0, 0);
    check("recursion_exc0", {16'd0, scr[100]}, 32'd512);
    check("recursion_exc39", {16'd0, scr[139]}, 32'd256);

    clear_mem();
    for (int a = 0; a < 4096; a++) scr_init[a] = 16'h7FFF;
    cst[tab]     = 16'h7FFF;
    cst[tab + 3] = 16'h7FFF;
    run("saturation", 100, 40, 0, 8, 0, 0);
    check("saturation_exc7", {16'd0, scr[107]}, 32'h7FFF);

    setup_halving();
    run("abort", 100, 40, 0, 40, 3 + 42 * 5, 0);
    run("restart", 100, 40, 0, 40, 0, 0);
    run("busy_start", 100, 40, 0, 40, 0, 300);

    run("len_zero", 100, 40, 0, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      int ea, t0, fr, ls;
      clear_mem();
      for (int a = 0; a < 4096; a++) scr_init[a] = 16'(int'($urandom_range(0, 8191)) - 4096);
      for (int c = 0; c < 31; c++) cst[tab + c] = 16'(int'($urandom_range(0, 16383)) - 8192);
      ea = int'($urandom_range(0, 4095));
      t0 = int'($urandom_range(20, 143));
      fr = int'($urandom_range(0, 4)) - 2;
      ls = int'($urandom_range(1, 40));
      run("random", ea, t0, fr, ls, 0, (r == 2) ? 50 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
